// File: rtl/game_result_banner.sv
// rtl/game_result_banner.sv - end-of-round W/L banner with timed show sequence and blink
// Optional screen border enabled by defining GAME_RESULT_BANNER_BORDER_EN.
module game_result_banner #(
  parameter int          SCREEN_WIDTH   = 1280,
  parameter int          SCREEN_HEIGHT  = 720,
  parameter logic [23:0] WIN_COLOR      = 24'h008000,
  parameter logic [23:0] LOSE_COLOR     = 24'h800000,
  parameter logic [23:0] FG_COLOR       = 24'hFFFFFF,
  parameter int          BLINK_FRAMES   = 30,
  parameter int          DISPLAY_FRAMES = 180,
  parameter int          BORDER_W       = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        new_frame_in,
  input  logic        start_in,
  input  logic        mode_in,
  output logic [23:0] pixel_out,
  output logic        showing_out,
  output logic        done_out
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_SHOW, S_DONE} state_t;

  localparam int SCW = (DISPLAY_FRAMES > 1) ? $clog2(DISPLAY_FRAMES) : 1;
  localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCW-1:0] SHOW_LAST  = SCW'(DISPLAY_FRAMES - 1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  localparam bit BLINK_EN = (BLINK_FRAMES > 0);

  localparam logic [10:0] H_END  = 11'(SCREEN_WIDTH);
  localparam logic [9:0]  V_END  = 10'(SCREEN_HEIGHT);
  localparam logic [10:0] COL_L0 = 11'(SCREEN_WIDTH * 20 / 100);
  localparam logic [10:0] COL_L1 = 11'(SCREEN_WIDTH * 32 / 100);
  localparam logic [10:0] COL_M0 = 11'(SCREEN_WIDTH * 44 / 100);
  localparam logic [10:0] COL_M1 = 11'(SCREEN_WIDTH * 56 / 100);
  localparam logic [10:0] COL_R0 = 11'(SCREEN_WIDTH * 68 / 100);
  localparam logic [10:0] COL_R1 = 11'(SCREEN_WIDTH * 80 / 100);
  localparam logic [9:0]  ROW_T  = 10'(SCREEN_HEIGHT * 20 / 100);
  localparam logic [9:0]  ROW_BB = 10'(SCREEN_HEIGHT * 68 / 100);
  localparam logic [9:0]  ROW_B  = 10'(SCREEN_HEIGHT * 80 / 100);

  state_t           state_q;
  logic [SCW-1:0]   show_cnt_q;
  logic [BCW-1:0]   blink_cnt_q;
  logic             phase_vis_q;
  logic             mode_q;
  logic             showing_q;
  logic             done_q;

  // Control FSM: sequence state, frame counters, blink phase and status outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      show_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_vis_q <= 1'b1;
      mode_q      <= 1'b0;
      showing_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_in) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (new_frame_in) begin
            state_q     <= S_SHOW;
            mode_q      <= mode_in;
            show_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_vis_q <= 1'b1;
            showing_q   <= 1'b1;
          end
        end
        S_SHOW: begin
          if (new_frame_in) begin
            show_cnt_q <= show_cnt_q + 1'b1;
            if (BLINK_EN) begin
              if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                phase_vis_q <= ~phase_vis_q;
              end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
              end
            end
            // Last frame of the show: enter DONE with the glyph forced visible.
            if (show_cnt_q == SHOW_LAST) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              phase_vis_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start_in) begin
            state_q   <= S_ARMED;
            showing_q <= 1'b0;
            done_q    <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_screen_d, glyph_hit_d, active_d, visible_d;
  logic in_rows, bar_l, bar_m, bar_r, bar_bot;

  always_comb begin
    in_screen_d = (hcount_in < H_END) && (vcount_in < V_END);
    in_rows     = (vcount_in >= ROW_T) && (vcount_in < ROW_B);
    bar_l       = in_rows && (hcount_in >= COL_L0) && (hcount_in < COL_L1);
    bar_m       = in_rows && (hcount_in >= COL_M0) && (hcount_in < COL_M1);
    bar_r       = in_rows && (hcount_in >= COL_R0) && (hcount_in < COL_R1);
    bar_bot     = (vcount_in >= ROW_BB) && (vcount_in < ROW_B) &&
                  (hcount_in >= COL_L0) && (hcount_in < COL_R1);
    glyph_hit_d = mode_q ? (bar_l | bar_m | bar_r | bar_bot) : (bar_l | bar_bot);
    active_d    = (state_q == S_SHOW) || (state_q == S_DONE);
    visible_d   = phase_vis_q || (state_q == S_DONE);
  end

`ifdef GAME_RESULT_BANNER_BORDER_EN
  localparam logic [10:0] BH_LO = 11'(BORDER_W);
  localparam logic [10:0] BH_HI = 11'(SCREEN_WIDTH - BORDER_W);
  localparam logic [9:0]  BV_LO = 10'(BORDER_W);
  localparam logic [9:0]  BV_HI = 10'(SCREEN_HEIGHT - BORDER_W);

  logic border_hit_d, border_hit_q;

  always_comb begin
    border_hit_d = (hcount_in < BH_LO) || (hcount_in >= BH_HI) ||
                   (vcount_in < BV_LO) || (vcount_in >= BV_HI);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) border_hit_q <= 1'b0;
    else           border_hit_q <= border_hit_d;
  end
`endif

  logic in_screen_q, glyph_hit_q, active_q, visible_q, mode_s1_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      in_screen_q <= 1'b0;
      glyph_hit_q <= 1'b0;
      active_q    <= 1'b0;
      visible_q   <= 1'b1;
      mode_s1_q   <= 1'b0;
    end else begin
      in_screen_q <= in_screen_d;
      glyph_hit_q <= glyph_hit_d;
      active_q    <= active_d;
      visible_q   <= visible_d;
      mode_s1_q   <= mode_q;
    end
  end

  logic [23:0] pixel_d, pixel_q;

  always_comb begin
    pixel_d = '0;
    if (!in_screen_q || !active_q) begin
      pixel_d = '0;
`ifdef GAME_RESULT_BANNER_BORDER_EN
    end else if (border_hit_q) begin
      pixel_d = FG_COLOR;
`endif
    end else if (glyph_hit_q && visible_q) begin
      pixel_d = FG_COLOR;
    end else begin
      pixel_d = mode_s1_q ? WIN_COLOR : LOSE_COLOR;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) pixel_q <= '0;
    else           pixel_q <= pixel_d;
  end

  assign pixel_out   = pixel_q;
  assign showing_out = showing_q;
  assign done_out    = done_q;

endmodule

// File: tb/tb_game_result_banner.sv
// tb/tb_game_result_banner.sv - directed scoreboard bench for game_result_banner
module tb_game_result_banner;

  localparam logic [23:0] FG   = 24'hFFFFFF;
  localparam logic [23:0] WIN  = 24'h008000;
  localparam logic [23:0] LOSE = 24'h800000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] hcount = 11'h7ff;
  logic [9:0]  vcount = '0;
  logic        new_frame = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [23:0] pixel;
  logic        showing, done;

  int vectors = 0;
  int miscompares = 0;
  logic [23:0] sb_q[$];
  string       tag_q[$];

  game_result_banner #(
    .SCREEN_WIDTH(100), .SCREEN_HEIGHT(50), .BLINK_FRAMES(2),
    .DISPLAY_FRAMES(5), .BORDER_W(4)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
    .new_frame_in(new_frame), .start_in(start), .mode_in(mode),
    .pixel_out(pixel), .showing_out(showing), .done_out(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Coordinates held for one cycle, then replaced by an off-screen filler so
  // only a 2-cycle pipeline returns the expected colour.
  task automatic pix(input int h, input int v, input logic [23:0] exp, input string tag);
    logic [23:0] e;
    string t;
    @(posedge clk); #1;
    hcount = 11'(h); vcount = 10'(v);
    sb_q.push_back(exp); tag_q.push_back(tag);
    @(posedge clk); #1;
    hcount = 11'h7ff; vcount = '0;
    @(posedge clk); #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk(t, pixel, e);
  endtask

  task automatic pulse(input logic s, input logic nf);
    @(posedge clk); #1;
    start = s; new_frame = nf;
    if (nf) begin hcount = '0; vcount = '0; end
    @(posedge clk); #1;
    start = 1'b0; new_frame = 1'b0; hcount = 11'h7ff;
  endtask

  task automatic status(input string tag, input logic exp_show, input logic exp_done);
    chk({tag, "_showing"}, {23'd0, showing}, {23'd0, exp_show});
    chk({tag, "_done"}, {23'd0, done}, {23'd0, exp_done});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] blink_win [5];
    logic [23:0] blink_lose[5];
    blink_win  = '{FG, FG, WIN, WIN, FG};
    blink_lose = '{FG, FG, LOSE, LOSE, FG};

    #2 rst_n = 1'b0;
    #1;
    chk("reset_pixel", pixel, 24'h0);
    status("reset", 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    pix(30, 20, 24'h0, "idle_pixel");

    // start and new_frame together: ARMED only
    mode = 1'b1;
    pulse(1'b1, 1'b1);
    status("armed", 1'b0, 1'b0);
    pix(25, 20, 24'h0, "armed_pixel");

    pulse(1'b0, 1'b1);
    status("show_entry", 1'b1, 1'b0);
    mode = 1'b0;
    pix(25, 20, FG,    "win_bar_l");
    pix(50, 20, FG,    "win_bar_m");
    pix(38, 20, WIN,   "win_gap");
    pix(50, 36, FG,    "win_bottom");
    pix(10, 5,  WIN,   "win_bg");
    pix(120, 5, 24'h0, "win_offscreen");
    pix(75, 20, FG,    "win_bar_r");
    pix(80, 20, WIN,   "win_bar_r_end");
    pix(50, 40, WIN,   "win_row_end");
`ifdef GAME_RESULT_BANNER_BORDER_EN
    pix(2, 20,  FG,  "border_left_vis");
    pix(97, 48, FG,  "border_corner_vis");
    pix(6, 20,  WIN, "border_inner_vis");
`endif
    for (int f = 1; f < 5; f++) begin
      pulse(1'b0, 1'b1);
      if (f == 2) begin
        pulse(1'b1, 1'b0);
        status("start_ignored", 1'b1, 1'b0);
`ifdef GAME_RESULT_BANNER_BORDER_EN
        pix(2, 20,  FG, "border_left_hid");
        pix(97, 48, FG, "border_corner_hid");
`endif
      end
      pix(25, 20, blink_win[f], $sformatf("win_blink_f%0d", f));
    end
    status("pre_done", 1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    status("win_done", 1'b1, 1'b1);
    pix(25, 20, FG, "win_done_pixel");
    pulse(1'b0, 1'b1);
    status("done_hold", 1'b1, 1'b1);

    // restart from DONE into a lose show
    pulse(1'b1, 1'b0);
    status("restart", 1'b0, 1'b0);
    pix(25, 20, 24'h0, "restart_armed_pixel");
    pulse(1'b0, 1'b1);
    status("lose_entry", 1'b1, 1'b0);
    pix(50, 20, LOSE, "lose_no_mid");
    pix(25, 20, FG,   "lose_bar_l");
    pix(50, 36, FG,   "lose_bottom");
    for (int f = 1; f < 5; f++) begin
      pulse(1'b0, 1'b1);
      pix(25, 20, blink_lose[f], $sformatf("lose_blink_f%0d", f));
    end
    pulse(1'b0, 1'b1);
    status("lose_done", 1'b1, 1'b1);
    pix(25, 20, FG, "lose_done_pixel");

    // reset in the middle of a show, with a non-zero pixel on the output
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    @(posedge clk); #1;
    hcount = 11'd38; vcount = 10'd20;
    repeat (3) @(posedge clk);
    #1 chk("pre_reset_pixel", pixel, LOSE);
    #2 rst_n = 1'b0;
    #1;
    chk("midshow_reset_pixel", pixel, 24'h0);
    status("midshow_reset", 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hcount = 11'h7ff; vcount = '0;
    pix(30, 20, 24'h0, "post_reset_pixel");
    pulse(1'b0, 1'b1);
    status("post_reset", 1'b0, 1'b0);
    pix(30, 20, 24'h0, "post_reset_frame_pixel");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/game_result_banner.md
Name: game_result_banner

Overview:
- Full-screen end-of-round banner for the HDMI pixel pipeline; replaces the static win-screen generator.
- Draws a block-letter "W" (win) or "L" (lose) glyph over a mode-coloured background.
- The glyph can blink at a frame-counted rate.
- Runs a timed show sequence: armed by a start pulse, shown for a fixed number of frames, then reports done to the game FSM.
- Pixel output is registered, with fixed 2-cycle latency from hcount_in/vcount_in.

Parameters:
- SCREEN_WIDTH, 1280, active pixels per line
- SCREEN_HEIGHT, 720, active lines per frame
- WIN_COLOR, 24'h008000, background in win mode
- LOSE_COLOR, 24'h800000, background in lose mode
- FG_COLOR, 24'hFFFFFF, glyph (and border) colour
- BLINK_FRAMES, 30, frames per blink half-period; 0 = no blinking
- DISPLAY_FRAMES, 180, frames spent in SHOW before DONE; must be >= 1
- BORDER_W, 8, border thickness in pixels (optional feature only)

Ports:
- clk_in  input  1  pixel clock
- rst_n_in  input  1  asynchronous active-low reset
- hcount_in  input  11  current pixel column
- vcount_in  input  10  current pixel row
- new_frame_in  input  1  one-cycle pulse at frame start (hcount 0, vcount 0)
- start_in  input  1  one-cycle request to begin a banner sequence
- mode_in  input  1  1 = win ("W"), 0 = lose ("L"); sampled at SHOW entry
- pixel_out  output  24  RGB pixel, 2 cycles after its coordinates
- showing_out  output  1  high while in SHOW or DONE
- done_out  output  1  high while in DONE

Behaviour:
- Reset: rst_n_in low asynchronously clears everything. pixel_out=0, showing_out=0, done_out=0, state=IDLE, all counters=0, blink phase=visible, latched mode=0.
- States:
  - IDLE: start_in -> ARMED.
  - ARMED: on new_frame_in -> SHOW. Latch mode_in, clear show_cnt and blink_cnt, set phase=visible.
  - SHOW: each new_frame_in increments show_cnt. new_frame_in with show_cnt==DISPLAY_FRAMES-1 -> DONE, so SHOW lasts exactly DISPLAY_FRAMES frames.
  - DONE: start_in -> ARMED. Otherwise hold.
- start_in in ARMED or SHOW is ignored.
- start_in and new_frame_in in the same cycle while IDLE: go to ARMED only; SHOW begins at the next new_frame_in.
- Blink: active only in SHOW with BLINK_FRAMES>0.
  - blink_cnt increments on new_frame_in.
  - At BLINK_FRAMES-1 it wraps to 0 and toggles the phase.
  - In DONE the phase is forced visible.
- Geometry: all boundaries are integer, truncated SCREEN_*×N/100, computed at elaboration. Intervals are start-inclusive, end-exclusive.
  - Vertical bars: columns [20%,32%), [44%,56%), [68%,80%); rows [20%,80%).
  - Bottom bar: columns [20%,80%); rows [68%,80%).
  - "W" = all three vertical bars + bottom bar.
  - "L" = left vertical bar + bottom bar.
- Pipeline:
  - Stage 1 registers in_screen, glyph_hit (and border_hit).
  - Stage 2 registers the colour mux.
  - State/phase are sampled at stage 1.
- Colour selection, first match wins:
  1. Off-screen (hcount>=SCREEN_WIDTH or vcount>=SCREEN_HEIGHT): 0.
  2. IDLE or ARMED: 0.
  3. glyph_hit and phase visible: FG_COLOR.
  4. Otherwise: WIN_COLOR or LOSE_COLOR per latched mode.
- showing_out and done_out are registered from state, with no pipeline alignment.
- Mode changes mid-show have no effect until the next SHOW entry.

Optional Feature:
- Macro GAME_RESULT_BANNER_BORDER_EN.
- When defined, in SHOW/DONE, on-screen pixels within BORDER_W of any screen edge output FG_COLOR regardless of blink phase. The border takes priority over the glyph and background.
- When undefined, there is no border logic and BORDER_W is unused.

Test Plan:
- Params: SCREEN_WIDTH=100, SCREEN_HEIGHT=50, BLINK_FRAMES=2, DISPLAY_FRAMES=5.
- Reset mid-SHOW: rst_n_in low -> pixel_out=0, showing_out=0, done_out=0 immediately. Release -> IDLE; pixel (30,20) stays 0.
- Win glyph: start_in, mode_in=1, then new_frame_in. In SHOW frame 0:
  - (25,20) -> FFFFFF
  - (50,20) -> FFFFFF
  - (38,20) -> 008000
  - (50,36) -> FFFFFF
  - (10,5) -> 008000
  - (120,5) -> 0
  - Each value appears exactly 2 cycles after its coordinates.
- Lose glyph: mode_in=0 -> (50,20) -> 800000, (25,20) -> FFFFFF, (50,36) -> FFFFFF.
- Blink/timing: across SHOW frames 0-4, (25,20) reads FFFFFF, FFFFFF, 800000, 800000, FFFFFF. After the 5th new_frame_in, done_out=1 and (25,20)=FFFFFF.
- Restart/ignore: start_in during SHOW frame 2 -> no change, DONE still after 5 frames. start_in in DONE -> done_out=0, showing_out=0; re-entry at next new_frame_in.
- Border (macro defined, BORDER_W=4): in SHOW, (2,20) -> FFFFFF and (97,48) -> FFFFFF in either blink phase. (6,20) -> background colour.
